// File: rtl/mdio_pkg.sv
// Shared constants, state type and frame builder for the Clause-22 MDIO master.
package mdio_pkg;

  localparam logic [1:0] MDIO_ST         = 2'b01;
  localparam logic [1:0] MDIO_OP_RD      = 2'b10;
  localparam logic [1:0] MDIO_OP_WR      = 2'b01;
  localparam int         MDIO_FRAME_BITS = 32;
  localparam int         MDIO_TA_BIT     = 15;

  typedef enum logic [1:0] {IDLE, PRE, FRAME, DONE} mdio_state_t;

  // Read frames carry don't-care TA/data bits; the master releases the bus for them.
  function automatic logic [31:0] mdio_frame(input logic write, input logic [4:0] phy,
                                             input logic [4:0] regad, input logic [15:0] wdat);
    return {MDIO_ST, (write ? MDIO_OP_WR : MDIO_OP_RD), phy, regad, 2'b10,
            (write ? wdat : 16'h0000)};
  endfunction

endpackage

// File: rtl/mdio_clk_div.sv
// MDC generator: low for CLK_DIV cycles, then high for CLK_DIV cycles, with phase strobes.
module mdio_clk_div #(
  parameter int CLK_DIV = 20
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  output logic mdc,
  output logic fall_stb,
  output logic samp_stb,
  output logic bit_end
);

  localparam int            CW   = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
      mdc <= 1'b0;
    end else if (clr) begin
      cnt <= '0;
      mdc <= 1'b0;
    end else if (cnt == LAST) begin
      cnt <= '0;
      mdc <= ~mdc;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Strobes are suppressed while cleared so the idle/done cycles never look like a bit.
  assign fall_stb = !clr && !mdc && (cnt == '0);
  assign samp_stb = !clr && !mdc && (cnt == LAST);
  assign bit_end  = !clr &&  mdc && (cnt == LAST);

endmodule

// File: rtl/mdio_master.sv
// Clause-22 MDIO master: one register read or write per request, preamble + 32-bit frame.
module mdio_master
  import mdio_pkg::*;
#(
  parameter int CLK_DIV      = 20,
  parameter int PREAMBLE_LEN = 32
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_vld,
  output logic        req_rdy,
  input  logic        req_write,
  input  logic [4:0]  req_phy,
  input  logic [4:0]  req_reg,
  input  logic [15:0] req_wdat,
  output logic        rsp_vld,
  output logic [15:0] rsp_dat,
  output logic        rsp_err,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic        mdio_i
);

  localparam logic [4:0] PRE_LAST    = 5'(PREAMBLE_LEN > 0 ? PREAMBLE_LEN - 1 : 0);
  localparam logic [4:0] FRAME_LAST  = 5'(MDIO_FRAME_BITS - 1);
  localparam logic [4:0] TA_SAMPLE   = 5'(MDIO_TA_BIT);
  localparam logic [4:0] RD_OE_LAST  = 5'(MDIO_TA_BIT - 3);

  mdio_state_t state;
  logic [4:0]  bit_cnt;
  logic [31:0] sreg;
  logic [15:0] rdat;
  logic        is_write;
  logic        ta_err;
  logic        fall_stb;
  logic        samp_stb;
  logic        bit_end;

  mdio_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .clk      (clk),
    .rstn     (rstn),
    .clr      ((state == IDLE) || (state == DONE)),
    .mdc      (mdc),
    .fall_stb (fall_stb),
    .samp_stb (samp_stb),
    .bit_end  (bit_end)
  );

  // sreg[31] always holds the next frame bit; it advances at the fall that starts driving the current one.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      sreg     <= '0;
      rdat     <= '0;
      is_write <= 1'b0;
      ta_err   <= 1'b0;
      req_rdy  <= 1'b1;
      rsp_vld  <= 1'b0;
      rsp_dat  <= '0;
      rsp_err  <= 1'b0;
      mdio_o   <= 1'b1;
      mdio_oe  <= 1'b0;
    end else begin
      rsp_vld <= 1'b0;
      case (state)
        IDLE: begin
          if (req_vld) begin
            req_rdy  <= 1'b0;
            is_write <= req_write;
            sreg     <= mdio_frame(req_write, req_phy, req_reg, req_wdat);
            bit_cnt  <= '0;
            rdat     <= '0;
            ta_err   <= 1'b0;
            mdio_oe  <= 1'b1;
            if (PREAMBLE_LEN == 0) begin
              state  <= FRAME;
              mdio_o <= MDIO_ST[1];
            end else begin
              state  <= PRE;
              mdio_o <= 1'b1;
            end
          end
        end
        PRE: begin
          if (bit_end) begin
            if (bit_cnt == PRE_LAST) begin
              state   <= FRAME;
              bit_cnt <= '0;
              mdio_o  <= sreg[31];
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
        end
        FRAME: begin
          if (fall_stb) sreg <= {sreg[30:0], 1'b1};
          if (samp_stb && !is_write) begin
            if (bit_cnt == TA_SAMPLE) ta_err <= mdio_i;
            else if (bit_cnt > TA_SAMPLE) rdat <= {rdat[14:0], mdio_i};
          end
          if (bit_end) begin
            if (bit_cnt == FRAME_LAST) begin
              state   <= DONE;
              rsp_vld <= 1'b1;
              rsp_dat <= is_write ? 16'h0000 : rdat;
              rsp_err <= is_write ? 1'b0 : ta_err;
              mdio_o  <= 1'b1;
              mdio_oe <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
              mdio_o  <= sreg[31];
              mdio_oe <= is_write || (bit_cnt <= RD_OE_LAST);
            end
          end
        end
        DONE: begin
          state   <= IDLE;
          req_rdy <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
